jt_sfg01_midi: RTL and testbench

- MIDI UART plus interrupt-vector unit of the SFG-01 cartridge; sibling slave on the same cartridge data bus as the FM core.
- Serves slot addresses #3FF2–#3FF7, decoded externally from the same chip-select chain as the FM core; this block sees only A2–A0.
- Runs a 31250-baud serial TX/RX pair.
- Drives the shared int_n line and supplies the Z80 IM2 vector during the interrupt-acknowledge cycle.

---
 rtl/jt_sfg01_pkg.sv | 32 +++
 rtl/jt_sfg01_midi_if.sv | 18 +
 rtl/jt_sfg01_midi_rx.sv | 116 +++++++++++
 rtl/jt_sfg01_midi.sv | 218 +++++++++++++++++++++
 tb/tb_jt_sfg01_midi.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jt_sfg01_pkg.sv
// Shared constants and state types for the SFG-01 MIDI UART / IM2 vector unit.
// Holds bit timing, register offsets, status/command bit indices and FSM enums.
package jt_sfg01_pkg;

    localparam int unsigned CLK_DIV  = 114;             // clk cycles per MIDI bit
    localparam int unsigned HALF_DIV = CLK_DIV / 2;     // start-bit centring delay
    localparam int unsigned CNT_W    = $clog2(CLK_DIV);

    localparam logic [2:0] REG_KBD  = 3'd2;
    localparam logic [2:0] REG_MVEC = 3'd3;
    localparam logic [2:0] REG_EVEC = 3'd4;
    localparam logic [2:0] REG_DATA = 3'd5;
    localparam logic [2:0] REG_CMD  = 3'd6;
    localparam logic [2:0] REG_RSV  = 3'd7;

    localparam int unsigned ST_TXRDY   = 0;
    localparam int unsigned ST_RXRDY   = 1;
    localparam int unsigned ST_TXEMPTY = 2;
    localparam int unsigned ST_OE      = 4;
    localparam int unsigned ST_FE      = 5;

    localparam int unsigned CMD_TXEN = 0;
    localparam int unsigned CMD_RXEN = 2;
    localparam int unsigned CMD_TXIE = 3;
    localparam int unsigned CMD_ER   = 4;
    localparam int unsigned CMD_RXIE = 5;
    localparam int unsigned CMD_IR   = 6;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/jt_sfg01_midi_if.sv
// Z80 cartridge-bus slice seen by the MIDI unit.
// master: CPU side drives strobes/address/data; slave: unit returns dout/dout_oe.
interface jt_sfg01_midi_if;
    logic       cs_n;
    logic [2:0] addr;
    logic       wr_n;
    logic       rd_n;
    logic       iorq_n;
    logic       mi;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dout_oe;

    modport master (output cs_n, addr, wr_n, rd_n, iorq_n, mi, din,
                    input  dout, dout_oe);
    modport slave  (input  cs_n, addr, wr_n, rd_n, iorq_n, mi, din,
                    output dout, dout_oe);
endinterface

// File: rtl/jt_sfg01_midi_rx.sv
// MIDI 8N1 receiver: 2-FF synchronizer, start-bit centring, 8 data samples, stop check.
// Ports: clk, rst (full reset), clr (internal reset), rxen, midi_rx (async serial in),
//        data/stb/fe (received byte, one-cycle store strobe, bad stop bit).
// Macro JT_SFG01_MIDI_THRU_EN adds midi_thru: synced line delayed 2 clk.
module jt_sfg01_midi_rx
    import jt_sfg01_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       rxen,
    input  logic       midi_rx,
    output logic [7:0] data,
    output logic       stb,
    output logic       fe
`ifdef JT_SFG01_MIDI_THRU_EN
    ,
    output logic       midi_thru
`endif
);

    logic             rx_s1, rx_s2, rx_s3;
    logic             fall_c;
    rx_state_t        state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       bit_cnt, bit_cnt_d;
    logic [7:0]       shift, shift_d, data_d;
    logic             stb_d, fe_d;

    // Synchronizer plus one extra stage for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            {rx_s1, rx_s2, rx_s3} <= 3'b111;
        end else begin
            {rx_s1, rx_s2, rx_s3} <= {midi_rx, rx_s1, rx_s2};
        end
    end

    assign fall_c = rx_s3 & ~rx_s2;

`ifdef JT_SFG01_MIDI_THRU_EN
    logic thru_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            thru_q    <= 1'b1;
            midi_thru <= 1'b1;
        end else begin
            thru_q    <= rx_s2;
            midi_thru <= thru_q;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            data    <= '0;
            stb     <= 1'b0;
            fe      <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_cnt <= bit_cnt_d;
            shift   <= shift_d;
            data    <= data_d;
            stb     <= stb_d;
            fe      <= fe_d;
        end
    end

    // Next-state: every sample lands mid-bit thanks to the half-bit start delay
    always_comb begin
        state_d   = state;
        cnt_d     = cnt + CNT_W'(1);
        bit_cnt_d = bit_cnt;
        shift_d   = shift;
        data_d    = data;
        stb_d     = 1'b0;
        fe_d      = fe;
        unique case (state)
            RX_IDLE: begin
                cnt_d = '0;
                if (rxen && fall_c) state_d = RX_START;
            end
            RX_START: begin
                if (cnt == CNT_W'(HALF_DIV - 1)) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s2, shift[7:1]};
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d   = '0;
                    stb_d   = 1'b1;
                    data_d  = shift;
                    fe_d    = ~rx_s2;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/jt_sfg01_midi.sv
// SFG-01 MIDI UART (31250 baud 8N1) with interrupt request and Z80 IM2 vector supply.
// Ports: clk, rst (sync, active-high), bus (CPU slice, slave modport), ext_irq_n
//        (keyboard irq, async), midi_rx (async serial in), midi_tx, int_n.
// dout/dout_oe are combinational so read data and vectors follow the strobes.
// Macro JT_SFG01_MIDI_THRU_EN adds the midi_thru output.
module jt_sfg01_midi
    import jt_sfg01_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    jt_sfg01_midi_if.slave bus,
    input  logic           ext_irq_n,
    input  logic           midi_rx,
    output logic           midi_tx,
    output logic           int_n
`ifdef JT_SFG01_MIDI_THRU_EN
    ,
    output logic           midi_thru
`endif
);

    logic             wr_n_q, rd_n_q, cs_q;
    logic [2:0]       addr_q;
    logic [1:0]       ext_s;
    logic             wr_stb_c, wr_cmd_c, wr_data_c, soft_rst_c, rd_data_c;
    logic [7:0]       mvec, evec, tx_hold, rx_data, status_c, rd_mux_c;
    logic             txen, rxen, txie, rxie, rx_rdy, oe, fe, midi_irq_c;
    logic [7:0]       rx_byte;
    logic             rx_stb, rx_fe;
    tx_state_t        tx_state, tx_state_d;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_d;
    logic [2:0]       tx_bit, tx_bit_d;
    logic [7:0]       tx_shift, tx_shift_d;
    logic             tx_rdy, tx_rdy_d, tx_load_c, tx_line_d, tx_cnt_end_c;

    // Strobe history for write-edge and read-release detection
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_n_q <= 1'b1;
            rd_n_q <= 1'b1;
            cs_q   <= 1'b1;
            addr_q <= '0;
            ext_s  <= 2'b11;
        end else begin
            wr_n_q <= bus.wr_n;
            rd_n_q <= bus.rd_n;
            cs_q   <= bus.cs_n;
            addr_q <= bus.addr;
            ext_s  <= {ext_s[0], ext_irq_n};
        end
    end

    assign wr_stb_c   = ~bus.cs_n & ~bus.wr_n & wr_n_q;
    assign wr_cmd_c   = wr_stb_c & (bus.addr == REG_CMD);
    assign wr_data_c  = wr_stb_c & (bus.addr == REG_DATA);
    assign soft_rst_c = wr_cmd_c & bus.din[CMD_IR];
    assign rd_data_c  = bus.rd_n & ~rd_n_q & ~cs_q & (addr_q == REG_DATA);
    assign midi_irq_c = (rxie & rx_rdy) | (txie & txen & tx_rdy);

    // Vectors survive the internal reset
    always_ff @(posedge clk) begin
        if (rst) begin
            mvec    <= '0;
            evec    <= '0;
            tx_hold <= '0;
        end else begin
            if (wr_stb_c && bus.addr == REG_MVEC) mvec <= bus.din;
            if (wr_stb_c && bus.addr == REG_EVEC) evec <= bus.din;
            if (wr_data_c) tx_hold <= bus.din;
        end
    end

    // Command bits, RX status and interrupt line; a store beats a same-cycle RxRDY clear
    always_ff @(posedge clk) begin
        if (rst || soft_rst_c) begin
            {txen, rxen, txie, rxie} <= 4'b0000;
            rx_rdy  <= 1'b0;
            oe      <= 1'b0;
            fe      <= 1'b0;
            rx_data <= '0;
            int_n   <= 1'b1;
        end else begin
            if (wr_cmd_c) begin
                txen <= bus.din[CMD_TXEN];
                rxen <= bus.din[CMD_RXEN];
                txie <= bus.din[CMD_TXIE];
                rxie <= bus.din[CMD_RXIE];
                if (bus.din[CMD_ER]) begin
                    oe <= 1'b0;
                    fe <= 1'b0;
                end
            end
            if (rx_stb) begin
                rx_data <= rx_byte;
                rx_rdy  <= 1'b1;
                if (rx_rdy && !rd_data_c) oe <= 1'b1;
                if (rx_fe) fe <= 1'b1;
            end else if (rd_data_c) begin
                rx_rdy <= 1'b0;
            end
            int_n <= ~(midi_irq_c | ~ext_s[1]);
        end
    end

    jt_sfg01_midi_rx u_rx (
        .clk       (clk),
        .rst       (rst),
        .clr       (soft_rst_c),
        .rxen      (rxen),
        .midi_rx   (midi_rx),
        .data      (rx_byte),
        .stb       (rx_stb),
        .fe        (rx_fe)
`ifdef JT_SFG01_MIDI_THRU_EN
        ,
        .midi_thru (midi_thru)
`endif
    );

    // TX state register
    always_ff @(posedge clk) begin
        if (rst || soft_rst_c) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_rdy   <= 1'b1;
            midi_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_bit   <= tx_bit_d;
            tx_shift <= tx_shift_d;
            tx_rdy   <= tx_rdy_d;
            midi_tx  <= tx_line_d;
        end
    end

    assign tx_cnt_end_c = (tx_cnt == CNT_W'(CLK_DIV - 1));

    // TX next-state; a full holding register at stop end chains straight into START
    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt + CNT_W'(1);
        tx_bit_d   = tx_bit;
        tx_shift_d = tx_shift;
        tx_rdy_d   = tx_rdy;
        tx_load_c  = 1'b0;
        tx_line_d  = 1'b1;
        unique case (tx_state)
            TX_IDLE: begin
                tx_cnt_d  = '0;
                tx_load_c = txen & ~tx_rdy;
            end
            TX_START: begin
                if (tx_cnt_end_c) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt_end_c) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = tx_bit + 3'd1;
                    tx_shift_d = {1'b1, tx_shift[7:1]};
                    if (tx_bit == 3'd7) tx_state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_cnt_end_c) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                    tx_load_c  = txen & ~tx_rdy;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (tx_load_c) begin
            tx_state_d = TX_START;
            tx_cnt_d   = '0;
            tx_shift_d = tx_hold;
            tx_rdy_d   = 1'b1;
        end
        if (wr_data_c) tx_rdy_d = 1'b0;
        case (tx_state_d)
            TX_START: tx_line_d = 1'b0;
            TX_DATA:  tx_line_d = tx_shift_d[0];
            default:  tx_line_d = 1'b1;
        endcase
    end

    // Read data / IM2 vector mux; acknowledge takes priority over a register read
    always_comb begin
        status_c              = '0;
        status_c[ST_TXRDY]    = tx_rdy;
        status_c[ST_RXRDY]    = rx_rdy;
        status_c[ST_TXEMPTY]  = tx_rdy & (tx_state == TX_IDLE);
        status_c[ST_OE]       = oe;
        status_c[ST_FE]       = fe;
        case (bus.addr)
            REG_DATA:         rd_mux_c = rx_data;
            REG_CMD:          rd_mux_c = status_c;
            REG_KBD, REG_RSV: rd_mux_c = 8'hFF;
            default:          rd_mux_c = 8'h00;
        endcase
        bus.dout    = 8'h00;
        bus.dout_oe = 1'b0;
        if (!bus.mi && !bus.iorq_n) begin
            bus.dout_oe = 1'b1;
            bus.dout    = midi_irq_c ? mvec : evec;
        end else if (!bus.cs_n && !bus.rd_n) begin
            bus.dout_oe = 1'b1;
            bus.dout    = rd_mux_c;
        end
    end

endmodule

// File: tb/tb_jt_sfg01_midi.sv
// Self-checking bench for jt_sfg01_midi: random TX/RX bytes against a frame/flag model.
module tb_jt_sfg01_midi;
    import jt_sfg01_pkg::*;

    logic clk = 1'b0;
    logic rst, ext_irq_n, midi_rx, midi_tx, int_n;
`ifdef JT_SFG01_MIDI_THRU_EN
    logic midi_thru;
`endif
    jt_sfg01_midi_if bus();

    jt_sfg01_midi dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ext_irq_n (ext_irq_n),
        .midi_rx   (midi_rx),
        .midi_tx   (midi_tx),
        .int_n     (int_n)
`ifdef JT_SFG01_MIDI_THRU_EN
        ,
        .midi_thru (midi_thru)
`endif
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    logic m_rdy, m_oe, m_fe;          // receiver flag model
    logic tx_q[$];                    // midi_tx captured once per clk
    logic [7:0] exp_q[$];             // bytes expected on midi_tx, in order
    logic rec_on = 1'b0;

    always @(negedge clk) if (rec_on) tx_q.push_back(midi_tx);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_status();
        return {2'b00, m_fe, m_oe, 1'b0, 1'b1, m_rdy, 1'b1};
    endfunction

    function automatic void model_store(input logic stop_ok);
        if (m_rdy) m_oe = 1'b1;
        if (!stop_ok) m_fe = 1'b1;
        m_rdy = 1'b1;
    endfunction

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.cs_n = 1'b0; bus.addr = a; bus.din = d; bus.wr_n = 1'b0;
        @(negedge clk);
        bus.cs_n = 1'b1; bus.wr_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.cs_n = 1'b0; bus.addr = a; bus.rd_n = 1'b0;
        #1 d = bus.dout;
        @(negedge clk);
        bus.cs_n = 1'b1; bus.rd_n = 1'b1;
    endtask

    task automatic ack(output logic [7:0] d, output logic oe);
        @(negedge clk);
        bus.mi = 1'b0; bus.iorq_n = 1'b0;
        #1 d = bus.dout; oe = bus.dout_oe;
        @(negedge clk);
        bus.mi = 1'b1; bus.iorq_n = 1'b1;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_ok);
        logic [9:0] frame;
        frame = {stop_ok, b, 1'b0};
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            midi_rx = frame[k];
            repeat (CLK_DIV) @(negedge clk);
        end
        midi_rx = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic check_status(input string name);
        logic [7:0] d;
        rd(REG_CMD, d);
        checks++;
        if (d !== exp_status()) begin
            errors++;
            $display("FAIL %s: status %h, required %h", name, d, exp_status());
        end
    endtask

    // Compare the captured line against back-to-back 8N1 frames of exp_q, then idle
    task automatic check_tx(input string name);
        int   i = -1;
        logic got, bad_v, expb, bad;
        logic [7:0] cur;
        for (int k = 0; k < 60 && k < tx_q.size(); k++)
            if (i < 0 && tx_q[k] === 1'b0) i = k;
        checks++;
        if (i < 0) begin
            errors++;
            $display("FAIL %s start: midi_tx never 0 within 60 clk, required 0", name);
            return;
        end
        foreach (exp_q[n]) begin
            cur = exp_q[n];
            for (int b = 0; b < 10; b++) begin
                expb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : cur[b-1];
                bad = 1'b0; bad_v = expb;
                for (int c = 0; c < CLK_DIV; c++) begin
                    got = (i < tx_q.size()) ? tx_q[i] : 1'bx;
                    if (got !== expb && !bad) begin bad = 1'b1; bad_v = got; end
                    i++;
                end
                checks++;
                if (bad) begin
                    errors++;
                    $display("FAIL %s byte %0d bit %0d: midi_tx %b, required %b", name, n, b, bad_v, expb);
                end
            end
        end
        bad = 1'b0; bad_v = 1'b1;
        for (int c = 0; c < CLK_DIV; c++) begin
            got = (i < tx_q.size()) ? tx_q[i] : 1'bx;
            if (got !== 1'b1 && !bad) begin bad = 1'b1; bad_v = got; end
            i++;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s idle: midi_tx %b, required 1", name, bad_v);
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_rdy = 1'b0; m_oe = 1'b0; m_fe = 1'b0;
        @(negedge clk);
        checks++;
        if ({midi_tx, int_n, bus.dout_oe} !== 3'b110 || bus.dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: tx/int_n/oe %b dout %h, required 110 dout 00",
                     {midi_tx, int_n, bus.dout_oe}, bus.dout);
        end
        check_status("reset_status");
        rd(REG_KBD, d);
        checks++;
        if (d !== 8'hFF) begin errors++; $display("FAIL read_reg2: %h, required ff", d); end
        wr(REG_RSV, 8'h12);
        rd(REG_RSV, d);
        checks++;
        if (d !== 8'hFF) begin errors++; $display("FAIL read_reg7: %h, required ff", d); end
    endtask

    task automatic test_tx_single();
        wr(REG_CMD, 8'h01);
        check_status("txen_status");
        tx_q.delete(); exp_q = '{8'h55};
        rec_on = 1'b1;
        wr(REG_DATA, 8'h55);
        repeat (300) @(negedge clk);
        begin
            logic [7:0] d;
            rd(REG_CMD, d);
            checks++;
            if (d !== 8'h01) begin errors++; $display("FAIL tx_busy_status: %h, required 01", d); end
        end
        repeat (CLK_DIV * 10) @(negedge clk);
        rec_on = 1'b0;
        check_status("tx_done_status");
        check_tx("tx_55");
    endtask

    task automatic test_back_to_back();
        tx_q.delete(); exp_q = '{8'hA5, 8'h3C};
        rec_on = 1'b1;
        wr(REG_DATA, 8'hA5);
        wr(REG_DATA, 8'h3C);
        repeat (CLK_DIV * 20 + 200) @(negedge clk);
        rec_on = 1'b0;
        check_tx("tx_b2b");
    endtask

    task automatic test_tx_random();
        logic [7:0] b, d;
        int polls;
        tx_q.delete(); exp_q.delete();
        rec_on = 1'b1;
        for (int n = 0; n < 3; n++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            polls = 0; d = 8'h00;
            while (d[ST_TXRDY] !== 1'b1 && polls < 2000) begin rd(REG_CMD, d); polls++; end
            checks++;
            if (d[ST_TXRDY] !== 1'b1) begin
                errors++;
                $display("FAIL tx_rdy_timeout: status %h, required TxRDY 1", d);
            end
            wr(REG_DATA, b);
        end
        repeat (CLK_DIV * 20 + 200) @(negedge clk);
        rec_on = 1'b0;
        check_tx("tx_random");
        wr(REG_CMD, 8'h00);
    endtask

    task automatic test_rx_irq();
        logic [7:0] d;
        logic found = 1'b0;
        wr(REG_CMD, 8'h24);
        @(negedge clk);
        bus.cs_n = 1'b0; bus.addr = REG_CMD; bus.rd_n = 1'b0;
        fork
            send_rx(8'h90, 1'b1);
            begin
                for (int c = 0; c < 1400 && !found; c++) begin
                    @(negedge clk);
                    #1 if (bus.dout[ST_RXRDY] === 1'b1) found = 1'b1;
                end
                checks++;
                if (!found || int_n !== 1'b1) begin
                    errors++;
                    $display("FAIL rx_rdy_edge: seen %b int_n %b, required seen 1 int_n 1", found, int_n);
                end
                @(negedge clk);
                checks++;
                if (int_n !== 1'b0) begin errors++; $display("FAIL rx_int: int_n %b, required 0", int_n); end
            end
        join
        @(negedge clk);
        bus.cs_n = 1'b1; bus.rd_n = 1'b1;
        model_store(1'b1);
        rd(REG_DATA, d);
        m_rdy = 1'b0;
        checks++;
        if (d !== 8'h90) begin errors++; $display("FAIL rx_data_90: %h, required 90", d); end
        repeat (3) @(negedge clk);
        checks++;
        if (int_n !== 1'b1) begin errors++; $display("FAIL rx_int_clear: int_n %b, required 1", int_n); end
        check_status("rx_after_read");
    endtask

    task automatic test_rx_errors();
        logic [7:0] b1, b2, b3, d;
        b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
        wr(REG_CMD, 8'h04);
        send_rx(b1, 1'b1); model_store(1'b1);
        send_rx(b2, 1'b1); model_store(1'b1);
        check_status("rx_overrun_status");
        rd(REG_DATA, d); m_rdy = 1'b0;
        checks++;
        if (d !== b2) begin errors++; $display("FAIL rx_overrun_data: %h, required %h", d, b2); end
        send_rx(b3, 1'b0); model_store(1'b0);
        check_status("rx_frame_status");
        wr(REG_CMD, 8'h14); m_oe = 1'b0; m_fe = 1'b0;
        check_status("rx_err_clear");
        rd(REG_DATA, d); m_rdy = 1'b0;
        checks++;
        if (d !== b3) begin errors++; $display("FAIL rx_fe_data: %h, required %h", d, b3); end
        // a low pulse shorter than half a bit is a glitch, not a start bit
        @(negedge clk); midi_rx = 1'b0;
        repeat (20) @(negedge clk); midi_rx = 1'b1;
        repeat (300) @(negedge clk);
        check_status("rx_glitch");
        for (int n = 0; n < 4; n++) begin
            logic ok;
            b1 = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            send_rx(b1, ok); model_store(ok);
            rd(REG_DATA, d); m_rdy = 1'b0;
            checks++;
            if (d !== b1) begin errors++; $display("FAIL rx_random_data %0d: %h, required %h", n, d, b1); end
            check_status("rx_random_status");
        end
    endtask

    task automatic test_vectors();
        logic [7:0] d, mv, ev;
        logic oe;
        wr(REG_MVEC, 8'h20);
        wr(REG_EVEC, 8'h30);
        wr(REG_CMD, 8'h40);
        m_rdy = 1'b0; m_oe = 1'b0; m_fe = 1'b0;
        check_status("ir_status");
        ext_irq_n = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (int_n !== 1'b0) begin errors++; $display("FAIL ext_int: int_n %b, required 0", int_n); end
        ack(d, oe);
        checks++;
        if (d !== 8'h30 || oe !== 1'b1) begin
            errors++; $display("FAIL ack_ext: dout %h oe %b, required 30 1", d, oe);
        end
        wr(REG_CMD, 8'h09);
        ack(d, oe);
        checks++;
        if (d !== 8'h20 || oe !== 1'b1) begin
            errors++; $display("FAIL ack_both: dout %h oe %b, required 20 1", d, oe);
        end
        ext_irq_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (int_n !== 1'b0) begin errors++; $display("FAIL ack_no_clear: int_n %b, required 0", int_n); end
        wr(REG_CMD, 8'h00);
        repeat (3) @(negedge clk);
        checks++;
        if (int_n !== 1'b1) begin errors++; $display("FAIL int_release: int_n %b, required 1", int_n); end
        for (int n = 0; n < 3; n++) begin
            mv = 8'($urandom); ev = 8'($urandom);
            wr(REG_MVEC, mv); wr(REG_EVEC, ev);
            ack(d, oe);
            checks++;
            if (d !== ev) begin errors++; $display("FAIL ack_rand_ext: dout %h, required %h", d, ev); end
            wr(REG_CMD, 8'h09);
            ack(d, oe);
            checks++;
            if (d !== mv) begin errors++; $display("FAIL ack_rand_midi: dout %h, required %h", d, mv); end
            wr(REG_CMD, 8'h00);
        end
    endtask

    initial begin
        rst = 1'b1; ext_irq_n = 1'b1; midi_rx = 1'b1;
        bus.cs_n = 1'b1; bus.addr = 3'd0; bus.wr_n = 1'b1; bus.rd_n = 1'b1;
        bus.iorq_n = 1'b1; bus.mi = 1'b1; bus.din = 8'h00;
        test_reset();
        test_tx_single();
        test_back_to_back();
        test_tx_random();
        test_rx_irq();
        test_rx_errors();
        test_vectors();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
